// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter and its test-frequency generator.
package freq_meter_pkg;

    localparam int CLK_HZ_DEFAULT = 50_000_000;
    localparam int FREQ_W         = 30;

    typedef logic [FREQ_W-1:0] freq_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RUN
    } fsm_state_e;

endpackage

// File: rtl/freq_word_div.sv
// Sequential shift-subtract divider: w = floor(f * 2^ACC_W / CLK_HZ), one quotient bit per cycle.
// FREQ_GEN_ROUND_EN adds one iteration and rounds the word to nearest.
module freq_word_div
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ    = CLK_HZ_DEFAULT,
    parameter int ACC_W     = 32,
    parameter int FRAC_ITER = ACC_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [FREQ_W-1:0] f,
    output logic              done,
    output logic [ACC_W-1:0]  w
);

`ifdef FREQ_GEN_ROUND_EN
    localparam int ITER = FRAC_ITER + 1;
`else
    localparam int ITER = FRAC_ITER;
`endif
    localparam int REM_W = $clog2(CLK_HZ) + 1;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [REM_W-1:0] DIVISOR = REM_W'(CLK_HZ);

    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] rem_sh;
    logic [ITER-1:0]  quo;
    logic [CNT_W-1:0] cnt;
    logic             active;

    // rem < CLK_HZ always, so the doubled value still fits in REM_W bits
    assign rem_sh = rem << 1;
    assign done   = active && (cnt == CNT_W'(ITER));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would chain iterations.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            rem    <= REM_W'(f);
            quo    <= '0;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
            end else begin
                if (rem_sh >= DIVISOR) begin
                    rem <= rem_sh - DIVISOR;
                    quo <= {quo[ITER-2:0], 1'b1};
                end else begin
                    rem <= rem_sh;
                    quo <= {quo[ITER-2:0], 1'b0};
                end
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef FREQ_GEN_ROUND_EN
    localparam logic [ACC_W:0] W_SAT = (ACC_W+1)'(1) << (ACC_W - 1);
    logic [ACC_W:0] w_sum;

    // The extra quotient bit is the half-LSB; add it and cap at half scale
    assign w_sum = {1'b0, ACC_W'(quo >> 1)} + (ACC_W+1)'(quo[0]);
    assign w     = (w_sum > W_SAT) ? W_SAT[ACC_W-1:0] : w_sum[ACC_W-1:0];
`else
    assign w = ACC_W'(quo);
`endif

endmodule

// File: rtl/freq_synth_gen.sv
// Programmable square-wave source: tuning word from freq_word_div drives a phase
// accumulator whose MSB is Fx_Out; Edge_Cnt counts Fx_Out rising edges per applied word.
module freq_synth_gen
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ    = CLK_HZ_DEFAULT,
    parameter int ACC_W     = 32,
    parameter int FRAC_ITER = ACC_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Load,
    input  logic [FREQ_W-1:0] Freq_Hz,
    output logic              Busy,
    output logic              Clamped,
    output logic [ACC_W-1:0]  Tuning_Word,
    output logic              Fx_Out,
    output logic [31:0]       Edge_Cnt
);

    localparam freq_t F_MAX = FREQ_W'(CLK_HZ / 2);

    fsm_state_e       state, state_next;
    logic             start;
    logic             apply;
    logic             div_done;
    logic [ACC_W-1:0] div_w;
    logic [ACC_W-1:0] acc;
    logic             req_zero;
    logic             fx_next;
    freq_t            f_clamped;

    assign f_clamped = (Freq_Hz > F_MAX) ? F_MAX : Freq_Hz;

    freq_word_div #(
        .CLK_HZ   (CLK_HZ),
        .ACC_W    (ACC_W),
        .FRAC_ITER(FRAC_ITER)
    ) u_div (
        .CLK  (CLK),
        .RST  (RST),
        .start(start),
        .f    (f_clamped),
        .done (div_done),
        .w    (div_w)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        apply      = 1'b0;
        unique case (state)
            IDLE, RUN: begin
                if (Load) begin
                    state_next = CALC;
                    start      = 1'b1;
                end
            end
            CALC: begin
                if (div_done) begin
                    apply      = 1'b1;
                    state_next = req_zero ? IDLE : RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign Busy = (state == CALC);

    // While a new word is computed the waveform keeps running on the old one
    assign fx_next = ((state == IDLE) || (apply && req_zero)) ? 1'b0 : acc[ACC_W-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc         <= '0;
            Tuning_Word <= '0;
            Fx_Out      <= 1'b0;
            Edge_Cnt    <= '0;
            Clamped     <= 1'b0;
            req_zero    <= 1'b0;
        end else begin
            if (start) begin
                Clamped  <= (Freq_Hz > F_MAX);
                req_zero <= (Freq_Hz == '0);
            end

            if (apply && req_zero) begin
                acc         <= '0;
                Tuning_Word <= '0;
            end else if (apply) begin
                acc         <= acc + div_w;
                Tuning_Word <= div_w;
            end else if (state == IDLE) begin
                acc <= '0;
            end else begin
                acc <= acc + Tuning_Word;
            end

            Fx_Out <= fx_next;

            if (apply)
                Edge_Cnt <= '0;
            else if (fx_next && !Fx_Out && (Edge_Cnt != '1))
                Edge_Cnt <= Edge_Cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_freq_synth_gen.sv
// Self-checking bench for freq_synth_gen: directed scenarios plus randomized loads,
// compared every cycle against a countdown/64-bit-division reference model.
module tb_freq_synth_gen;
    import freq_meter_pkg::*;

    localparam int CLK_HZ = 50_000_000;
`ifdef FREQ_GEN_ROUND_EN
    localparam int LAT   = 34;
    localparam bit ROUND = 1'b1;
`else
    localparam int LAT   = 33;
    localparam bit ROUND = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        Load;
    logic [29:0] Freq_Hz;
    logic        Busy;
    logic        Clamped;
    logic [31:0] Tuning_Word;
    logic        Fx_Out;
    logic [31:0] Edge_Cnt;

    int checks   = 0;
    int failures = 0;

    freq_synth_gen #(
        .CLK_HZ   (CLK_HZ),
        .ACC_W    (32),
        .FRAC_ITER(32)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Load       (Load),
        .Freq_Hz    (Freq_Hz),
        .Busy       (Busy),
        .Clamped    (Clamped),
        .Tuning_Word(Tuning_Word),
        .Fx_Out     (Fx_Out),
        .Edge_Cnt   (Edge_Cnt)
    );

    always #5 CLK = ~CLK;

    // Reference word straight from the arithmetic definition
    function automatic logic [31:0] ref_word(input logic [29:0] f);
        longint unsigned fc, q;
        fc = (f > CLK_HZ / 2) ? longint'(CLK_HZ / 2) : longint'(f);
        if (ROUND) begin
            q = (fc << 33) / CLK_HZ;
            q = (q >> 1) + (q & 64'd1);
            if (q > 64'h8000_0000) q = 64'h8000_0000;
        end else begin
            q = (fc << 32) / CLK_HZ;
        end
        return q[31:0];
    endfunction

    // Reference model state
    bit          m_busy    = 1'b0;
    int          m_left    = 0;
    bit          m_clamped = 1'b0;
    bit          m_pzero   = 1'b0;
    bit          m_fx      = 1'b0;
    logic [31:0] m_pw      = '0;
    logic [31:0] m_tw      = '0;
    logic [31:0] m_acc     = '0;
    logic [31:0] m_edges   = '0;

    always @(posedge CLK) begin : ref_model
        logic [31:0] old_acc;
        bit          old_fx;
        bit          applied;
        old_acc = m_acc;
        old_fx  = m_fx;
        applied = 1'b0;
        if (RST) begin
            m_busy = 0; m_left = 0; m_clamped = 0; m_pzero = 0; m_fx = 0;
            m_pw = '0; m_tw = '0; m_acc = '0; m_edges = '0;
        end else begin
            m_acc = old_acc + m_tw;
            m_fx  = old_acc[31];
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy  = 1'b0;
                    applied = 1'b1;
                    m_edges = '0;
                    if (m_pzero) begin
                        m_tw = '0; m_acc = '0; m_fx = 1'b0;
                    end else begin
                        m_tw  = m_pw;
                        m_acc = old_acc + m_pw;
                    end
                end
            end else if (Load) begin
                m_busy    = 1'b1;
                m_left    = LAT;
                m_pw      = ref_word(Freq_Hz);
                m_pzero   = (Freq_Hz == 0);
                m_clamped = (Freq_Hz > CLK_HZ / 2);
            end
            if (!applied && m_fx && !old_fx && (m_edges != 32'hFFFF_FFFF))
                m_edges = m_edges + 1;
        end
    end

    // Advance n cycles, comparing every output with the model mid-cycle
    task automatic run_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            checks += 5;
            if (Busy !== m_busy) begin
                failures++;
                $display("FAIL %s busy got=%b exp=%b t=%0t", tag, Busy, m_busy, $time);
            end
            if (Clamped !== m_clamped) begin
                failures++;
                $display("FAIL %s clamped got=%b exp=%b t=%0t", tag, Clamped, m_clamped, $time);
            end
            if (Tuning_Word !== m_tw) begin
                failures++;
                $display("FAIL %s tuning_word got=%h exp=%h t=%0t", tag, Tuning_Word, m_tw, $time);
            end
            if (Fx_Out !== m_fx) begin
                failures++;
                $display("FAIL %s fx_out got=%b exp=%b t=%0t", tag, Fx_Out, m_fx, $time);
            end
            if (Edge_Cnt !== m_edges) begin
                failures++;
                $display("FAIL %s edge_cnt got=%0d exp=%0d t=%0t", tag, Edge_Cnt, m_edges, $time);
            end
        end
    endtask

    // Pulse Load, optionally pulse a second Load after extra_at busy cycles, wait for apply
    task automatic load_and_wait(input logic [29:0] f, input string tag,
                                 input int extra_at, input logic [29:0] extra_f,
                                 output int busy_len);
        Load    = 1'b1;
        Freq_Hz = f;
        run_cycles(1, tag);
        Load     = 1'b0;
        busy_len = Busy ? 1 : 0;
        while (Busy && busy_len < 200) begin
            if (busy_len == extra_at) begin
                Load    = 1'b1;
                Freq_Hz = extra_f;
            end
            run_cycles(1, tag);
            Load = 1'b0;
            if (Busy) busy_len++;
        end
        checks++;
        if (Busy) begin
            failures++;
            $display("FAIL %s busy_timeout got=busy exp=idle_within_200", tag);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; Load = 1'b1; Freq_Hz = 30'd12_500_000;
        run_cycles(2, "reset");
        RST = 1'b0; Load = 1'b0;
        run_cycles(1, "reset");
        checks += 3;
        if (Busy !== 1'b0) begin
            failures++; $display("FAIL reset_over_load busy got=%b exp=0", Busy);
        end
        if (Tuning_Word !== 32'd0) begin
            failures++; $display("FAIL reset tuning_word got=%h exp=0", Tuning_Word);
        end
        if ({Fx_Out, Clamped, Edge_Cnt} !== 34'd0) begin
            failures++; $display("FAIL reset outputs got=%b/%b/%0d exp=0/0/0", Fx_Out, Clamped, Edge_Cnt);
        end
    endtask

    task automatic test_basic();
        int len, ones;
        load_and_wait(30'd12_500_000, "basic", 0, 30'd0, len);
        checks += 3;
        if (len != LAT) begin
            failures++; $display("FAIL basic busy_len got=%0d exp=%0d", len, LAT);
        end
        if (Tuning_Word !== 32'h4000_0000) begin
            failures++; $display("FAIL basic word got=%h exp=40000000", Tuning_Word);
        end
        if (Edge_Cnt !== 32'd0) begin
            failures++; $display("FAIL basic edge_clear got=%0d exp=0", Edge_Cnt);
        end
        ones = 0;
        for (int i = 0; i < 1000; i++) begin
            run_cycles(1, "basic");
            if (Fx_Out) ones++;
        end
        checks += 2;
        if (Edge_Cnt !== 32'd250) begin
            failures++; $display("FAIL basic edges_1000 got=%0d exp=250", Edge_Cnt);
        end
        if (ones != 500) begin
            failures++; $display("FAIL basic duty got=%0d exp=500", ones);
        end
    endtask

    task automatic test_low_freq();
        int len;
        load_and_wait(30'd1, "low", 0, 30'd0, len);
        checks += 2;
        if (Tuning_Word !== (ROUND ? 32'd86 : 32'd85)) begin
            failures++; $display("FAIL low word got=%0d exp=%0d", Tuning_Word, ROUND ? 86 : 85);
        end
        if (Clamped !== 1'b0) begin
            failures++; $display("FAIL low clamped got=%b exp=0", Clamped);
        end
        run_cycles(40, "low");
    endtask

    task automatic test_clamp();
        int  len;
        bit  prev;
        load_and_wait(30'd30_000_000, "clamp", 0, 30'd0, len);
        checks += 2;
        if (Clamped !== 1'b1) begin
            failures++; $display("FAIL clamp flag got=%b exp=1", Clamped);
        end
        if (Tuning_Word !== 32'h8000_0000) begin
            failures++; $display("FAIL clamp word got=%h exp=80000000", Tuning_Word);
        end
        run_cycles(1, "clamp");
        prev = Fx_Out;
        for (int i = 0; i < 10; i++) begin
            run_cycles(1, "clamp");
            checks++;
            if (Fx_Out === prev) begin
                failures++; $display("FAIL clamp toggle got=%b exp=%b", Fx_Out, !prev);
            end
            prev = Fx_Out;
        end
    endtask

    task automatic test_zero();
        int len;
        load_and_wait(30'd0, "zero", 0, 30'd0, len);
        checks += 3;
        if (len != LAT) begin
            failures++; $display("FAIL zero busy_len got=%0d exp=%0d", len, LAT);
        end
        if (Tuning_Word !== 32'd0) begin
            failures++; $display("FAIL zero word got=%h exp=0", Tuning_Word);
        end
        if (Fx_Out !== 1'b0) begin
            failures++; $display("FAIL zero fx got=%b exp=0", Fx_Out);
        end
        run_cycles(20, "zero");
    endtask

    task automatic test_ignore_in_calc();
        int len;
        load_and_wait(30'd12_500_000, "ignore", 10, 30'd1_000_000, len);
        checks += 2;
        if (len != LAT) begin
            failures++; $display("FAIL ignore busy_len got=%0d exp=%0d", len, LAT);
        end
        if (Tuning_Word !== 32'h4000_0000) begin
            failures++; $display("FAIL ignore word got=%h exp=40000000", Tuning_Word);
        end
        run_cycles(50, "ignore");
        load_and_wait(30'd1_000_000, "rerun", 0, 30'd0, len);
        checks += 2;
        if (Tuning_Word !== ref_word(30'd1_000_000)) begin
            failures++; $display("FAIL rerun word got=%h exp=%h", Tuning_Word, ref_word(30'd1_000_000));
        end
        if (Edge_Cnt !== 32'd0) begin
            failures++; $display("FAIL rerun edge_clear got=%0d exp=0", Edge_Cnt);
        end
        run_cycles(60, "rerun");
    endtask

    task automatic test_reset_mid_calc();
        int len;
        Load = 1'b1; Freq_Hz = 30'd7_000_000;
        run_cycles(1, "rst_mid");
        Load = 1'b0;
        run_cycles(15, "rst_mid");
        RST = 1'b1;
        run_cycles(1, "rst_mid");
        RST = 1'b0;
        checks++;
        if ({Busy, Clamped, Fx_Out, Tuning_Word, Edge_Cnt} !== 67'd0) begin
            failures++;
            $display("FAIL rst_mid outputs got=%b/%b/%b/%h/%0d exp=all_zero",
                     Busy, Clamped, Fx_Out, Tuning_Word, Edge_Cnt);
        end
        load_and_wait(30'd12_500_000, "rst_after", 0, 30'd0, len);
        checks += 2;
        if (len != LAT) begin
            failures++; $display("FAIL rst_after busy_len got=%0d exp=%0d", len, LAT);
        end
        if (Tuning_Word !== 32'h4000_0000) begin
            failures++; $display("FAIL rst_after word got=%h exp=40000000", Tuning_Word);
        end
        run_cycles(20, "rst_after");
    endtask

    task automatic test_random();
        int          len, sel, extra;
        logic [29:0] f, f2;
        for (int it = 0; it < 10; it++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       f = 30'($urandom_range(25_000_000, 30'h3FFF_FFFF));
                1:       f = 30'($urandom_range(1, 1000));
                default: f = 30'($urandom_range(1, 25_000_000));
            endcase
            extra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : 0;
            f2    = 30'($urandom_range(0, 25_000_000));
            load_and_wait(f, "random", extra, f2, len);
            checks += 3;
            if (len != LAT) begin
                failures++; $display("FAIL random busy_len got=%0d exp=%0d", len, LAT);
            end
            if (Tuning_Word !== ref_word(f)) begin
                failures++; $display("FAIL random word f=%0d got=%h exp=%h", f, Tuning_Word, ref_word(f));
            end
            if (Clamped !== (f > 30'd25_000_000)) begin
                failures++; $display("FAIL random clamped f=%0d got=%b exp=%b", f, Clamped, f > 30'd25_000_000);
            end
            run_cycles($urandom_range(20, 300), "random");
        end
    endtask

    initial begin
        RST     = 1'b1;
        Load    = 1'b0;
        Freq_Hz = '0;
        test_reset();
        test_basic();
        test_low_freq();
        test_clamp();
        test_zero();
        test_ignore_in_calc();
        test_reset_mid_calc();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
